// File: rtl/fft_peak_search_if.sv
// Bundles the snooped port-A strobe, read port B and the peak-search result
// bus into one connection between the RAM side and the peak search block.
interface fft_peak_search_if #(
  parameter int AW    = 9,
  parameter int MAG_W = 16
);
  logic             ram_we_a;
  logic [AW-1:0]    ram_addr_a;
  logic             ram_en_b;
  logic [AW-1:0]    ram_addr_b;
  logic [MAG_W-1:0] ram_dout_b;
  logic [MAG_W-1:0] peak_thresh;
  logic             peak_valid;
  logic [AW-1:0]    peak_bin;
  logic [MAG_W-1:0] peak_mag;
  logic             peak_detect;
  logic [15:0]      frame_cnt;
  logic             busy;
  logic             overrun;

  modport master (
    output ram_we_a, ram_addr_a, ram_dout_b, peak_thresh,
    input  ram_en_b, ram_addr_b, peak_valid, peak_bin, peak_mag,
           peak_detect, frame_cnt, busy, overrun
  );

  modport slave (
    input  ram_we_a, ram_addr_a, ram_dout_b, peak_thresh,
    output ram_en_b, ram_addr_b, peak_valid, peak_bin, peak_mag,
           peak_detect, frame_cnt, busy, overrun
  );
endinterface

// File: rtl/fft_peak_search.sv
// Scans the FFT magnitude RAM after each completed frame write and reports
// the largest bin, its magnitude, a threshold flag and a frame count.
module fft_peak_search #(
  parameter int NPOINT    = 1024,
  parameter int MAG_W     = 16,
  parameter int SKIP_BINS = 1,
  parameter int RD_LAT    = 1,
  parameter int AW        = (NPOINT / 2 > 1) ? $clog2(NPOINT / 2) : 1
) (
  input  logic               sys_clk,
  input  logic               sys_rstn,
  fft_peak_search_if.slave   bus
);
  localparam int            HALF      = NPOINT / 2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(HALF - 1);
  localparam logic [AW-1:0] SKIP_ADDR = AW'(SKIP_BINS);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

  state_t           state_reg, state_next;
  logic [MAG_W-1:0] best_mag_reg;
  logic [AW-1:0]    best_bin_reg;
  logic [MAG_W-1:0] thresh_reg;
  logic             first_reg;
  logic             vld_sr [1:RD_LAT];
  logic [AW-1:0]    addr_sr [1:RD_LAT];
  logic             trigger;
  logic             in_flight;

  assign trigger = bus.ram_we_a && (bus.ram_addr_a == LAST_ADDR);

  // Reads still travelling toward the compare stage; the final compare
  // happens on the same edge that leaves DRAIN.
  always_comb begin
    in_flight = bus.ram_en_b;
    for (int i = 1; i < RD_LAT; i++) begin
      in_flight = in_flight | vld_sr[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (trigger) state_next = SCAN;
      SCAN:    if (bus.ram_addr_b == LAST_ADDR) state_next = DRAIN;
      DRAIN:   if (!in_flight) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      for (int i = 1; i <= RD_LAT; i++) begin
        vld_sr[i]  <= 1'b0;
        addr_sr[i] <= '0;
      end
    end else begin
      for (int i = RD_LAT; i > 1; i--) begin
        vld_sr[i]  <= vld_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end
      vld_sr[1]  <= bus.ram_en_b;
      addr_sr[1] <= bus.ram_addr_b;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      bus.ram_en_b    <= 1'b0;
      bus.ram_addr_b  <= '0;
      bus.peak_valid  <= 1'b0;
      bus.peak_bin    <= '0;
      bus.peak_mag    <= '0;
      bus.peak_detect <= 1'b0;
      bus.frame_cnt   <= '0;
      bus.busy        <= 1'b0;
      bus.overrun     <= 1'b0;
      best_mag_reg    <= '0;
      best_bin_reg    <= '0;
      thresh_reg      <= '0;
      first_reg       <= 1'b0;
    end else begin
      bus.peak_valid <= 1'b0;
      bus.overrun    <= trigger && (state_reg != IDLE);

      // Strictly-greater update keeps the lowest bin on ties.
      if (vld_sr[RD_LAT]) begin
        if (first_reg || (bus.ram_dout_b > best_mag_reg)) begin
          best_mag_reg <= bus.ram_dout_b;
          best_bin_reg <= addr_sr[RD_LAT];
        end
        first_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (trigger) begin
            bus.busy       <= 1'b1;
            bus.ram_en_b   <= 1'b1;
            bus.ram_addr_b <= SKIP_ADDR;
            thresh_reg     <= bus.peak_thresh;
            best_mag_reg   <= '0;
            best_bin_reg   <= SKIP_ADDR;
            first_reg      <= 1'b1;
          end
        end
        SCAN: begin
          if (bus.ram_addr_b == LAST_ADDR) begin
            bus.ram_en_b <= 1'b0;
          end else begin
            bus.ram_addr_b <= bus.ram_addr_b + AW'(1);
          end
        end
        REPORT: begin
          bus.peak_valid  <= 1'b1;
          bus.peak_bin    <= best_bin_reg;
          bus.peak_mag    <= best_mag_reg;
          bus.peak_detect <= (best_mag_reg >= thresh_reg);
          bus.frame_cnt   <= bus.frame_cnt + 16'd1;
          bus.busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_peak_search.sv
// Four peak-search instances (NPOINT=16) over one shared magnitude table:
// 0: SKIP=1 RD_LAT=1, 1: SKIP=0 RD_LAT=1, 2: SKIP=1 RD_LAT=2, 3: SKIP=1 RD_LAT=3.
module tb_fft_peak_search;
  logic        clk = 1'b0;
  logic        rstn;
  logic        we;
  logic [2:0]  addr_a;
  logic [15:0] thresh;
  int          sel;
  logic [15:0] mem [8];
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  pv_all, det_all, busy_all, ovr_all, en_all;
  logic [2:0]  bin_all  [4];
  logic [15:0] mag_all  [4];
  logic [15:0] fcnt_all [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int SKIP = (gi == 1) ? 0 : 1;
    localparam int RL   = (gi < 2) ? 1 : gi;
    fft_peak_search_if #(.AW(3), .MAG_W(16)) bus ();
    logic [15:0] rd_pipe [1:3];

    assign bus.ram_we_a    = we && (sel == gi);
    assign bus.ram_addr_a  = addr_a;
    assign bus.peak_thresh = thresh;
    assign bus.ram_dout_b  = rd_pipe[RL];

    always @(posedge clk) begin
      if (bus.ram_en_b) rd_pipe[1] <= mem[bus.ram_addr_b];
      rd_pipe[2] <= rd_pipe[1];
      rd_pipe[3] <= rd_pipe[2];
    end

    fft_peak_search #(.NPOINT(16), .MAG_W(16), .SKIP_BINS(SKIP), .RD_LAT(RL), .AW(3)) dut (
      .sys_clk  (clk),
      .sys_rstn (rstn),
      .bus      (bus)
    );

    assign pv_all[gi]   = bus.peak_valid;
    assign det_all[gi]  = bus.peak_detect;
    assign busy_all[gi] = bus.busy;
    assign ovr_all[gi]  = bus.overrun;
    assign en_all[gi]   = bus.ram_en_b;
    assign bin_all[gi]  = bus.peak_bin;
    assign mag_all[gi]  = bus.peak_mag;
    assign fcnt_all[gi] = bus.frame_cnt;
  end

  typedef struct {
    int          dut;
    logic [2:0]  bin;
    logic [15:0] mag;
    logic        det;
    logic [15:0] fcnt;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   pv_cnt = 0, ovr_cnt = 0;
  int   en_cnt [4];
  int   fc [4];

  // Advance one cycle; any result strobe is matched against the scoreboard.
  task automatic step();
    exp_t e;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      if (en_all[d]) en_cnt[d]++;
      if (ovr_all[d]) ovr_cnt++;
      if (pv_all[d]) begin
        pv_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: dut=%0d cyc=%0d bin=%0d mag=%h, required no result",
                   d, cyc, bin_all[d], mag_all[d]);
        end else begin
          e = exp_q.pop_front();
          if (d !== e.dut || bin_all[d] !== e.bin || mag_all[d] !== e.mag ||
              det_all[d] !== e.det || fcnt_all[d] !== e.fcnt || cyc !== e.cyc) begin
            errors++;
            $display("FAIL result: got dut=%0d bin=%0d mag=%h det=%b fcnt=%0d cyc=%0d, required dut=%0d bin=%0d mag=%h det=%b fcnt=%0d cyc=%0d",
                     d, bin_all[d], mag_all[d], det_all[d], fcnt_all[d], cyc,
                     e.dut, e.bin, e.mag, e.det, e.fcnt, e.cyc);
          end else begin
            $display("result dut=%0d bin=%0d mag=%h det=%b fcnt=%0d cyc=%0d ok",
                     d, bin_all[d], mag_all[d], det_all[d], fcnt_all[d], cyc);
          end
        end
      end
    end
  endtask

  task automatic expect_result(input int d, input logic [2:0] bin, input logic [15:0] mag,
                               input logic det, input int e0, input int rl, input int n);
    exp_t e;
    fc[d]++;
    e.dut = d; e.bin = bin; e.mag = mag; e.det = det;
    e.fcnt = 16'(fc[d]); e.cyc = e0 + n + rl + 1;
    exp_q.push_back(e);
  endtask

  task automatic write_frame(output int e0);
    e0 = 0;
    for (int a = 0; a < 8; a++) begin
      we = 1'b1; addr_a = 3'(a);
      if (a == 7) e0 = cyc + 1;
      step();
    end
    we = 1'b0;
  endtask

  task automatic trigger_only(output int e0);
    we = 1'b1; addr_a = 3'd7; e0 = cyc + 1;
    step();
    we = 1'b0;
  endtask

  task automatic wait_done(input int n);
    repeat (n) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL result_missing: pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (pv_all[d] !== 1'b0 || det_all[d] !== 1'b0 || busy_all[d] !== 1'b0 ||
          ovr_all[d] !== 1'b0 || en_all[d] !== 1'b0 || bin_all[d] !== 3'd0 ||
          mag_all[d] !== 16'd0 || fcnt_all[d] !== 16'd0) begin
        errors++;
        $display("FAIL %s dut=%0d: pv=%b det=%b busy=%b ovr=%b en=%b bin=%0d mag=%h fcnt=%0d, required all 0",
                 name, d, pv_all[d], det_all[d], busy_all[d], ovr_all[d], en_all[d],
                 bin_all[d], mag_all[d], fcnt_all[d]);
      end else begin
        $display("%s dut=%0d all outputs 0 ok", name, d);
      end
    end
  endtask

  task automatic fill_mem(input logic [15:0] v);
    for (int i = 0; i < 8; i++) mem[i] = v;
  endtask

  task automatic test_reset();
    rstn = 1'b1; we = 1'b0; addr_a = 3'd0; thresh = 16'd0; sel = 0;
    fill_mem(16'd0);
    for (int d = 0; d < 4; d++) begin en_cnt[d] = 0; fc[d] = 0; end
    #2 rstn = 1'b0;
    repeat (3) step();
    check_idle_outputs("reset");
    rstn = 1'b1;
    step();
  endtask

  task automatic test_ramp();
    int e0;
    for (int i = 0; i < 8; i++) mem[i] = 16'(i * 10);
    thresh = 16'd0; sel = 0;
    write_frame(e0);
    expect_result(0, 3'd7, 16'd70, 1'b1, e0, 1, 7);
    checks++;
    if (busy_all[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_during_scan: got %b required 1", busy_all[0]);
    end
    wait_done(14);
    checks++;
    if (bin_all[0] !== 3'd7 || mag_all[0] !== 16'd70 || busy_all[0] !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_report: bin=%0d mag=%0d busy=%b required bin=7 mag=70 busy=0",
               bin_all[0], mag_all[0], busy_all[0]);
    end
  endtask

  task automatic test_tie();
    int e0;
    fill_mem(16'h0010);
    mem[3] = 16'h0400; mem[5] = 16'h0400;
    thresh = 16'h0400; sel = 0;
    write_frame(e0);
    expect_result(0, 3'd3, 16'h0400, 1'b1, e0, 1, 7);
    wait_done(14);
    // Threshold is captured at the trigger; a later change must not matter.
    thresh = 16'h0401;
    trigger_only(e0);
    thresh = 16'd0;
    expect_result(0, 3'd3, 16'h0400, 1'b0, e0, 1, 7);
    wait_done(14);
  endtask

  task automatic test_skip();
    int e0;
    fill_mem(16'd0);
    mem[0] = 16'hFFFF; mem[6] = 16'h0100;
    thresh = 16'd0;
    sel = 0;
    trigger_only(e0);
    expect_result(0, 3'd6, 16'h0100, 1'b1, e0, 1, 7);
    wait_done(14);
    sel = 1;
    trigger_only(e0);
    expect_result(1, 3'd0, 16'hFFFF, 1'b1, e0, 1, 8);
    wait_done(14);
    sel = 0;
  endtask

  task automatic test_zero();
    int e0;
    fill_mem(16'd0);
    sel = 0; thresh = 16'd0;
    trigger_only(e0);
    expect_result(0, 3'd1, 16'd0, 1'b1, e0, 1, 7);
    wait_done(14);
    thresh = 16'd1;
    trigger_only(e0);
    expect_result(0, 3'd1, 16'd0, 1'b0, e0, 1, 7);
    wait_done(14);
  endtask

  task automatic test_no_trigger();
    int p0;
    p0 = pv_cnt; sel = 0;
    for (int a = 0; a < 7; a++) begin
      we = 1'b1; addr_a = 3'(a);
      step();
    end
    we = 1'b0; addr_a = 3'd7;
    repeat (15) step();
    checks++;
    if (pv_cnt !== p0 || busy_all[0] !== 1'b0) begin
      errors++;
      $display("FAIL no_trigger: valid_count=%0d busy=%b required 0 and 0", pv_cnt - p0, busy_all[0]);
    end
  endtask

  task automatic test_overrun();
    int e0, o0, p0;
    for (int i = 0; i < 8; i++) mem[i] = 16'(i * 10);
    thresh = 16'd0; sel = 0;
    o0 = ovr_cnt; p0 = pv_cnt;
    trigger_only(e0);
    expect_result(0, 3'd7, 16'd70, 1'b1, e0, 1, 7);
    step(); step();
    we = 1'b1; addr_a = 3'd7;
    step();
    we = 1'b0;
    wait_done(14);
    checks++;
    if (ovr_cnt - o0 !== 1 || pv_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL overrun: overrun_pulses=%0d valids=%0d required 1 and 1", ovr_cnt - o0, pv_cnt - p0);
    end
  endtask

  task automatic test_reset_mid();
    int e0, p0;
    for (int i = 0; i < 8; i++) mem[i] = 16'(i * 10);
    thresh = 16'd0; sel = 0;
    p0 = pv_cnt;
    trigger_only(e0);
    repeat (3) step();
    rstn = 1'b0;
    step(); step();
    check_idle_outputs("reset_mid");
    rstn = 1'b1;
    for (int d = 0; d < 4; d++) fc[d] = 0;
    repeat (12) step();
    checks++;
    if (pv_cnt !== p0) begin
      errors++;
      $display("FAIL reset_mid_no_valid: valids=%0d required 0", pv_cnt - p0);
    end
    trigger_only(e0);
    expect_result(0, 3'd7, 16'd70, 1'b1, e0, 1, 7);
    wait_done(14);
  endtask

  task automatic test_rdlat();
    int e0, rl;
    fill_mem(16'd0);
    mem[4] = 16'h1234;
    thresh = 16'h1234;
    for (int d = 0; d < 4; d++) begin
      if (d != 1) begin
        rl = (d == 0) ? 1 : d;
        sel = d;
        en_cnt[d] = 0;
        write_frame(e0);
        expect_result(d, 3'd4, 16'h1234, 1'b1, e0, rl, 7);
        wait_done(16);
        checks++;
        if (en_cnt[d] !== 7) begin
          errors++;
          $display("FAIL en_width dut=%0d: got %0d cycles required 7", d, en_cnt[d]);
        end
      end
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_tie();
    test_skip();
    test_zero();
    test_no_trigger();
    test_overrun();
    test_reset_mid();
    test_rdlat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
